vn_message_unit: RTL and testbench

Variable-node message unit for the layered 5G NR LDPC decoder. It sits on both sides of the check node decoder for one layer. Upstream, it turns APP LLRs and the previous-iteration CN messages into VN→CN messages. Downstream, it combines the returned CN messages with the buffered VN messages to produce updated APP LLRs for write-back. Edges are streamed one Z-wide block per beat, with valid/ready handshakes on the inputs and on the APP output.

---
 rtl/vn_message_unit_pkg.sv | 28 ++
 rtl/vn_message_unit_if.sv | 46 ++++
 rtl/vn_message_unit_edge_buffer.sv | 30 +++
 rtl/vn_message_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_vn_message_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vn_message_unit_pkg.sv
// Shared types and helpers for the LDPC variable-node message unit.
// sat_sym serves both the VN-message and APP-LLR clipping stages.
package vn_message_unit_pkg;

   localparam int EDGE_W = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXTRACT = 2'd1,
      UPDATE  = 2'd2,
      DONE    = 2'd3
   } vnu_state_t;

   // Symmetric clip to +/-(2^(width-1)-1); the most-negative code never appears.
   function automatic logic signed [31:0] sat_sym(input logic signed [31:0] value,
                                                  input int width);
      logic signed [31:0] lim;
      lim = (32'sd1 <<< (width - 1)) - 32'sd1;
      if (value > lim) begin
         return lim;
      end
      if (value < -lim) begin
         return -lim;
      end
      return value;
   endfunction

endpackage

// File: rtl/vn_message_unit_if.sv
// Bundle of the control, streaming and status signals of vn_message_unit.
// slave is the unit itself, master is whatever drives it.
interface vn_message_unit_if #(
   parameter int Z          = 56,
   parameter int DATA_WIDTH = 6,
   parameter int APP_WIDTH  = 8
);

   logic                                        start;
   logic [vn_message_unit_pkg::EDGE_W-1:0]      active_degree;
   logic [Z-1:0][APP_WIDTH-1:0]                 app_in;
   logic [Z-1:0][DATA_WIDTH-1:0]                r_old_in;
   logic                                        app_in_valid;
   logic                                        app_in_ready;
   logic [Z-1:0][DATA_WIDTH-1:0]                vn_msg_out;
   logic                                        vn_msg_valid;
   logic [vn_message_unit_pkg::EDGE_W-1:0]      vn_msg_edge;
   logic [Z-1:0][DATA_WIDTH-1:0]                cn_msg_in;
   logic                                        cn_msg_in_valid;
   logic                                        cn_msg_in_ready;
   logic [Z-1:0][APP_WIDTH-1:0]                 app_out;
   logic [vn_message_unit_pkg::EDGE_W-1:0]      app_out_edge;
   logic                                        app_out_valid;
   logic                                        app_out_ready;
   logic                                        busy;
   logic                                        layer_done;
   logic                                        cfg_err;
   logic                                        sat_flag;

   modport slave (
      input  start, active_degree, app_in, r_old_in, app_in_valid,
             cn_msg_in, cn_msg_in_valid, app_out_ready,
      output app_in_ready, vn_msg_out, vn_msg_valid, vn_msg_edge,
             cn_msg_in_ready, app_out, app_out_edge, app_out_valid,
             busy, layer_done, cfg_err, sat_flag
   );

   modport master (
      output start, active_degree, app_in, r_old_in, app_in_valid,
             cn_msg_in, cn_msg_in_valid, app_out_ready,
      input  app_in_ready, vn_msg_out, vn_msg_valid, vn_msg_edge,
             cn_msg_in_ready, app_out, app_out_edge, app_out_valid,
             busy, layer_done, cfg_err, sat_flag
   );

endinterface

// File: rtl/vn_message_unit_edge_buffer.sv
// Per-edge storage of VN->CN messages for one layer: written during
// extraction, read combinationally during the APP update.
module vn_edge_buffer #(
   parameter int Z          = 56,
   parameter int DATA_WIDTH = 6,
   parameter int DEPTH      = 30,
   parameter int ADDR_W     = 6
) (
   input  logic                         clk,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [Z-1:0][DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [Z-1:0][DATA_WIDTH-1:0] rd_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [Z-1:0][DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr < ADDR_W'(DEPTH))) begin
         mem[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

   // Out-of-range addresses read as zero rather than aliasing a real slot.
   assign rd_data = (rd_addr < ADDR_W'(DEPTH)) ? mem[rd_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/vn_message_unit.sv
// Variable-node message unit: q = sat(app - r_old) on the way into the check
// node, app' = sat(q + r_new) on the way back, one Z-wide edge per beat.
module vn_message_unit
   import vn_message_unit_pkg::*;
#(
   parameter int Z             = 56,
   parameter int DATA_WIDTH    = 6,
   parameter int APP_WIDTH     = 8,
   parameter int MAX_CN_DEGREE = 30
) (
   input logic             clk,
   input logic             rst_n,
   vn_message_unit_if.slave bus
);

   vnu_state_t                   state_q, state_d;
   logic [EDGE_W-1:0]            deg_q, deg_d;
   logic [EDGE_W-1:0]            edge_q, edge_d;
   logic                         cn_done_q, cn_done_d;
   logic                         sat_flag_q, sat_flag_d;
   logic [Z-1:0][DATA_WIDTH-1:0] vn_msg_out_q, vn_msg_out_d;
   logic                         vn_msg_valid_q, vn_msg_valid_d;
   logic [EDGE_W-1:0]            vn_msg_edge_q, vn_msg_edge_d;
   logic [Z-1:0][APP_WIDTH-1:0]  app_out_q, app_out_d;
   logic [EDGE_W-1:0]            app_out_edge_q, app_out_edge_d;
   logic                         app_out_valid_q, app_out_valid_d;
   logic                         busy_q, busy_d;
   logic                         layer_done_q, layer_done_d;
   logic                         cfg_err_q, cfg_err_d;

   logic [Z-1:0][DATA_WIDTH-1:0] q_lane;
   logic [Z-1:0]                 q_clip;
   logic [Z-1:0][APP_WIDTH-1:0]  a_lane;
   logic [Z-1:0]                 a_clip;
   logic [Z-1:0][DATA_WIDTH-1:0] buf_rd;

   logic app_in_ready;
   logic cn_ready;
   logic app_accept;
   logic cn_accept;
   logic out_handshake;
   logic degree_ok;
   logic last_edge;

   assign app_in_ready  = (state_q == EXTRACT);
   // cn_done_q stops a stray beat past the last edge from being consumed.
   assign cn_ready      = (state_q == UPDATE) && !cn_done_q &&
                          (!app_out_valid_q || bus.app_out_ready);
   assign app_accept    = app_in_ready && bus.app_in_valid;
   assign cn_accept     = cn_ready && bus.cn_msg_in_valid;
   assign out_handshake = app_out_valid_q && bus.app_out_ready;
   assign degree_ok     = (bus.active_degree != '0) &&
                          (bus.active_degree <= EDGE_W'(MAX_CN_DEGREE));
   assign last_edge     = (edge_q == (deg_q - EDGE_W'(1)));

   vn_edge_buffer #(
      .Z          (Z),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MAX_CN_DEGREE),
      .ADDR_W     (EDGE_W)
   ) u_edge_buffer (
      .clk     (clk),
      .wr_en   (app_accept),
      .wr_addr (edge_q),
      .wr_data (q_lane),
      .rd_addr (edge_q),
      .rd_data (buf_rd)
   );

   for (genvar gi = 0; gi < Z; gi++) begin : g_lane
      logic [APP_WIDTH:0]  diff;
      logic [DATA_WIDTH:0] sum;
      logic signed [31:0]  diff_ext;
      logic signed [31:0]  sum_ext;
      logic signed [31:0]  q_full;
      logic signed [31:0]  a_full;

      assign diff     = {bus.app_in[gi][APP_WIDTH-1], bus.app_in[gi]}
                      - {{(APP_WIDTH + 1 - DATA_WIDTH){bus.r_old_in[gi][DATA_WIDTH-1]}},
                         bus.r_old_in[gi]};
      assign diff_ext = {{(31 - APP_WIDTH){diff[APP_WIDTH]}}, diff};
      assign q_full   = sat_sym(diff_ext, DATA_WIDTH);
      assign q_lane[gi] = q_full[DATA_WIDTH-1:0];
      assign q_clip[gi] = (q_full != diff_ext);

      assign sum      = {buf_rd[gi][DATA_WIDTH-1], buf_rd[gi]}
                      + {bus.cn_msg_in[gi][DATA_WIDTH-1], bus.cn_msg_in[gi]};
      assign sum_ext  = {{(31 - DATA_WIDTH){sum[DATA_WIDTH]}}, sum};
      assign a_full   = sat_sym(sum_ext, APP_WIDTH);
      assign a_lane[gi] = a_full[APP_WIDTH-1:0];
      assign a_clip[gi] = (a_full != sum_ext);
   end

   always_comb begin
      state_d         = state_q;
      deg_d           = deg_q;
      edge_d          = edge_q;
      cn_done_d       = cn_done_q;
      sat_flag_d      = sat_flag_q;
      vn_msg_out_d    = vn_msg_out_q;
      vn_msg_valid_d  = 1'b0;
      vn_msg_edge_d   = vn_msg_edge_q;
      app_out_d       = app_out_q;
      app_out_edge_d  = app_out_edge_q;
      app_out_valid_d = app_out_valid_q;
      layer_done_d    = 1'b0;
      cfg_err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (degree_ok) begin
                  state_d    = EXTRACT;
                  deg_d      = bus.active_degree;
                  edge_d     = '0;
                  cn_done_d  = 1'b0;
                  sat_flag_d = 1'b0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         EXTRACT: begin
            if (app_accept) begin
               vn_msg_out_d   = q_lane;
               vn_msg_valid_d = 1'b1;
               vn_msg_edge_d  = edge_q;
               if (|q_clip) begin
                  sat_flag_d = 1'b1;
               end
               if (last_edge) begin
                  state_d = UPDATE;
                  edge_d  = '0;
               end else begin
                  edge_d = edge_q + EDGE_W'(1);
               end
            end
         end
         UPDATE: begin
            if (out_handshake) begin
               app_out_valid_d = 1'b0;
            end
            if (cn_accept) begin
               app_out_d       = a_lane;
               app_out_edge_d  = edge_q;
               app_out_valid_d = 1'b1;
               if (|a_clip) begin
                  sat_flag_d = 1'b1;
               end
               if (last_edge) begin
                  cn_done_d = 1'b1;
               end else begin
                  edge_d = edge_q + EDGE_W'(1);
               end
            end
            // Once the last edge is in, the output register can only hold that edge.
            if (cn_done_q && out_handshake) begin
               state_d      = DONE;
               layer_done_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         deg_q           <= '0;
         edge_q          <= '0;
         cn_done_q       <= 1'b0;
         sat_flag_q      <= 1'b0;
         vn_msg_out_q    <= '0;
         vn_msg_valid_q  <= 1'b0;
         vn_msg_edge_q   <= '0;
         app_out_q       <= '0;
         app_out_edge_q  <= '0;
         app_out_valid_q <= 1'b0;
         busy_q          <= 1'b0;
         layer_done_q    <= 1'b0;
         cfg_err_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         deg_q           <= deg_d;
         edge_q          <= edge_d;
         cn_done_q       <= cn_done_d;
         sat_flag_q      <= sat_flag_d;
         vn_msg_out_q    <= vn_msg_out_d;
         vn_msg_valid_q  <= vn_msg_valid_d;
         vn_msg_edge_q   <= vn_msg_edge_d;
         app_out_q       <= app_out_d;
         app_out_edge_q  <= app_out_edge_d;
         app_out_valid_q <= app_out_valid_d;
         busy_q          <= busy_d;
         layer_done_q    <= layer_done_d;
         cfg_err_q       <= cfg_err_d;
      end
   end

   assign bus.app_in_ready    = app_in_ready;
   assign bus.cn_msg_in_ready = cn_ready;
   assign bus.vn_msg_out      = vn_msg_out_q;
   assign bus.vn_msg_valid    = vn_msg_valid_q;
   assign bus.vn_msg_edge     = vn_msg_edge_q;
   assign bus.app_out         = app_out_q;
   assign bus.app_out_edge    = app_out_edge_q;
   assign bus.app_out_valid   = app_out_valid_q;
   assign bus.busy            = busy_q;
   assign bus.layer_done      = layer_done_q;
   assign bus.cfg_err         = cfg_err_q;
   assign bus.sat_flag        = sat_flag_q;

endmodule

// File: tb/tb_vn_message_unit.sv
// Bench for vn_message_unit: directed and random layers against an integer
// model of the VN/APP update, plus a narrow-APP instance for APP clipping.
module tb_vn_message_unit;

   localparam int Z  = 56;
   localparam int DW = 6;
   localparam int AW = 8;
   localparam int Z2 = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vn_message_unit_if #(.Z(Z),  .DATA_WIDTH(DW), .APP_WIDTH(AW)) bus1 ();
   vn_message_unit_if #(.Z(Z2), .DATA_WIDTH(DW), .APP_WIDTH(6))  bus2 ();

   vn_message_unit #(.Z(Z), .DATA_WIDTH(DW), .APP_WIDTH(AW), .MAX_CN_DEGREE(30)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   vn_message_unit #(.Z(Z2), .DATA_WIDTH(DW), .APP_WIDTH(6), .MAX_CN_DEGREE(30)) u_dut_a6 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   int total = 0;
   int bad   = 0;

   int app_v [30][Z];
   int r_v   [30][Z];
   int cn_v  [30][Z];
   int q_m   [30][Z];
   int a_m   [30][Z];
   bit sat_m;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clamp(input int x, input int lim);
      if (x > lim) return lim;
      if (x < -lim) return -lim;
      return x;
   endfunction

   // Reference: q = clip6(app - r_old), app' = clip8(q + r_new), sticky clip flag.
   task automatic model(input int deg);
      sat_m = 1'b0;
      for (int e = 0; e < deg; e++) begin
         for (int l = 0; l < Z; l++) begin
            q_m[e][l] = clamp(app_v[e][l] - r_v[e][l], 31);
            if (q_m[e][l] != app_v[e][l] - r_v[e][l]) sat_m = 1'b1;
            a_m[e][l] = clamp(q_m[e][l] + cn_v[e][l], 127);
            if (a_m[e][l] != q_m[e][l] + cn_v[e][l]) sat_m = 1'b1;
         end
      end
   endtask

   task automatic gen_const(input int deg, input int app, input int r, input int cn);
      for (int e = 0; e < deg; e++) begin
         for (int l = 0; l < Z; l++) begin
            app_v[e][l] = app;
            r_v[e][l]   = r;
            cn_v[e][l]  = cn;
         end
      end
   endtask

   task automatic gen_random(input int deg);
      for (int e = 0; e < deg; e++) begin
         for (int l = 0; l < Z; l++) begin
            app_v[e][l] = int'($urandom_range(0, 255)) - 128;
            r_v[e][l]   = int'($urandom_range(0, 63)) - 32;
            cn_v[e][l]  = int'($urandom_range(0, 62)) - 31;
         end
      end
   endtask

   function automatic logic [511:0] pack_q(input int e);
      logic [511:0] v;
      v = '0;
      for (int l = 0; l < Z; l++) v[l*DW +: DW] = DW'(q_m[e][l]);
      return v;
   endfunction

   function automatic logic [511:0] pack_a(input int e);
      logic [511:0] v;
      v = '0;
      for (int l = 0; l < Z; l++) v[l*AW +: AW] = AW'(a_m[e][l]);
      return v;
   endfunction

   task automatic begin_layer(input int deg, input bit hold_start);
      bus1.start = 1'b1;
      bus1.active_degree = 6'(deg);
      @(negedge clk);
      if (hold_start) bus1.active_degree = 6'd0;
      else bus1.start = 1'b0;
      chk("start_busy", 512'(bus1.busy), 512'(1));
      chk("start_app_in_ready", 512'(bus1.app_in_ready), 512'(1));
      chk("start_sat_cleared", 512'(bus1.sat_flag), 512'(0));
   endtask

   task automatic do_extract(input int deg);
      for (int e = 0; e < deg; e++) begin
         for (int l = 0; l < Z; l++) begin
            bus1.app_in[l]   = AW'(app_v[e][l]);
            bus1.r_old_in[l] = DW'(r_v[e][l]);
         end
         bus1.app_in_valid = 1'b1;
         chk("ext_ready", 512'(bus1.app_in_ready), 512'(1));
         @(negedge clk);
         bus1.app_in_valid = 1'b0;
         chk("vn_valid", 512'(bus1.vn_msg_valid), 512'(1));
         chk("vn_msg", 512'(bus1.vn_msg_out), pack_q(e));
         chk("vn_edge", 512'(bus1.vn_msg_edge), 512'(e));
         chk("ext_no_cfg_err", 512'(bus1.cfg_err), 512'(0));
         if (e < deg - 1 && $urandom_range(0, 3) == 0) begin
            for (int l = 0; l < Z; l++) bus1.app_in[l] = AW'($urandom);
            @(negedge clk);
            chk("vn_gap_valid", 512'(bus1.vn_msg_valid), 512'(0));
         end
      end
      bus1.start = 1'b0;
      chk("upd_entry_in_ready", 512'(bus1.app_in_ready), 512'(0));
      chk("upd_entry_cn_ready", 512'(bus1.cn_msg_in_ready), 512'(1));
   endtask

   task automatic do_update(input int deg, input int bp_edge, input int bp_cycles);
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      int bp_left = bp_cycles;
      while (got < deg && cyc < 400) begin
         bus1.cn_msg_in_valid = (sent < deg);
         if (sent < deg) begin
            for (int l = 0; l < Z; l++) bus1.cn_msg_in[l] = DW'(cn_v[sent][l]);
         end
         bus1.app_out_ready = 1'b1;
         if (bus1.app_out_valid && int'(bus1.app_out_edge) == bp_edge && bp_left > 0) begin
            bus1.app_out_ready = 1'b0;
            bp_left--;
         end
         #1;
         if (bus1.app_out_valid) begin
            chk("app_out", 512'(bus1.app_out), pack_a(got));
            chk("app_out_edge", 512'(bus1.app_out_edge), 512'(got));
         end
         if (sent < deg) chk("cn_ready", 512'(bus1.cn_msg_in_ready), 512'(bus1.app_out_ready));
         chk("upd_no_done", 512'(bus1.layer_done), 512'(0));
         if (bus1.app_out_valid && bus1.app_out_ready) got++;
         if (bus1.cn_msg_in_valid && bus1.cn_msg_in_ready) sent++;
         @(negedge clk);
         cyc++;
      end
      bus1.cn_msg_in_valid = 1'b0;
      bus1.app_out_ready = 1'b1;
      chk("upd_all_beats", 512'(got), 512'(deg));
      chk("layer_done_pulse", 512'(bus1.layer_done), 512'(1));
      chk("done_busy", 512'(bus1.busy), 512'(1));
      chk("done_out_valid", 512'(bus1.app_out_valid), 512'(0));
      @(negedge clk);
      chk("idle_busy", 512'(bus1.busy), 512'(0));
      chk("idle_done_low", 512'(bus1.layer_done), 512'(0));
      chk("sat_flag", 512'(bus1.sat_flag), 512'(sat_m));
   endtask

   task automatic run_layer(input int deg, input int bp_edge, input int bp_cycles, input bit hold_start);
      model(deg);
      begin_layer(deg, hold_start);
      do_extract(deg);
      do_update(deg, bp_edge, bp_cycles);
      $display("layer deg=%0d bp_edge=%0d bp_cycles=%0d sat=%0d", deg, bp_edge, bp_cycles, sat_m);
   endtask

   task automatic cfg_reject(input int deg);
      bus1.start = 1'b1;
      bus1.active_degree = 6'(deg);
      @(negedge clk);
      bus1.start = 1'b0;
      chk("cfg_err_pulse", 512'(bus1.cfg_err), 512'(1));
      chk("cfg_err_busy", 512'(bus1.busy), 512'(0));
      @(negedge clk);
      chk("cfg_err_clear", 512'(bus1.cfg_err), 512'(0));
      chk("cfg_err_still_idle", 512'(bus1.busy), 512'(0));
      $display("start rejected deg=%0d", deg);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] exp2;
      bus1.start = 0; bus1.active_degree = 0; bus1.app_in = '0; bus1.r_old_in = '0;
      bus1.app_in_valid = 0; bus1.cn_msg_in = '0; bus1.cn_msg_in_valid = 0; bus1.app_out_ready = 1;
      bus2.start = 0; bus2.active_degree = 0; bus2.app_in = '0; bus2.r_old_in = '0;
      bus2.app_in_valid = 0; bus2.cn_msg_in = '0; bus2.cn_msg_in_valid = 0; bus2.app_out_ready = 1;

      repeat (2) @(negedge clk);
      chk("rst_busy", 512'(bus1.busy), 512'(0));
      chk("rst_vn_valid", 512'(bus1.vn_msg_valid), 512'(0));
      chk("rst_out_valid", 512'(bus1.app_out_valid), 512'(0));
      chk("rst_app_out", 512'(bus1.app_out), 512'(0));
      chk("rst_in_ready", 512'(bus1.app_in_ready), 512'(0));
      chk("rst_cn_ready", 512'(bus1.cn_msg_in_ready), 512'(0));
      chk("rst_sat", 512'(bus1.sat_flag), 512'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Nominal: 10 - 4 = 6, then 6 + (-2) = 4, no clipping.
      gen_const(3, 10, 4, -2);
      run_layer(3, 99, 0, 1'b0);

      // VN clipping in both directions, then a clean layer clears the flag.
      gen_const(2, 0, 0, 0);
      for (int l = 0; l < Z; l++) begin
         app_v[0][l] = 100;  r_v[0][l] = -20;
         app_v[1][l] = -127; r_v[1][l] = 31;
      end
      run_layer(2, 99, 0, 1'b0);
      gen_const(1, 5, 1, 1);
      run_layer(1, 99, 0, 1'b0);

      // Backpressure on edge 1 for three cycles.
      gen_random(3);
      run_layer(3, 1, 3, 1'b0);

      cfg_reject(0);
      cfg_reject(31);

      // start held high throughout a layer must not restart it or flag an error.
      gen_random(2);
      run_layer(2, 99, 0, 1'b1);

      // Boundary degrees and random layers.
      gen_random(30);
      run_layer(30, int'($urandom_range(0, 29)), 2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         int d;
         d = int'($urandom_range(1, 30));
         gen_random(d);
         run_layer(d, int'($urandom_range(0, d - 1)), int'($urandom_range(0, 4)), 1'b0);
      end

      // Asynchronous reset in the middle of UPDATE with app_out_valid high.
      gen_random(4);
      model(4);
      begin_layer(4, 1'b0);
      do_extract(4);
      bus1.app_out_ready = 1'b0;
      bus1.cn_msg_in_valid = 1'b1;
      for (int l = 0; l < Z; l++) bus1.cn_msg_in[l] = DW'(cn_v[0][l]);
      @(negedge clk);
      chk("pre_rst_out_valid", 512'(bus1.app_out_valid), 512'(1));
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 512'(bus1.app_out_valid), 512'(0));
      chk("arst_app_out", 512'(bus1.app_out), 512'(0));
      chk("arst_busy", 512'(bus1.busy), 512'(0));
      chk("arst_cn_ready", 512'(bus1.cn_msg_in_ready), 512'(0));
      chk("arst_vn_out", 512'(bus1.vn_msg_out), 512'(0));
      $display("async reset mid-update");
      @(negedge clk);
      rst_n = 1'b1;
      bus1.cn_msg_in_valid = 1'b0;
      bus1.app_out_ready = 1'b1;
      @(negedge clk);
      gen_random(1);
      run_layer(1, 99, 0, 1'b0);

      // Narrow APP instance: 31 + 31 clips to 31.
      bus2.start = 1'b1;
      bus2.active_degree = 6'd1;
      @(negedge clk);
      bus2.start = 1'b0;
      for (int l = 0; l < Z2; l++) begin
         bus2.app_in[l] = 6'd31;
         bus2.r_old_in[l] = 6'd0;
      end
      bus2.app_in_valid = 1'b1;
      @(negedge clk);
      bus2.app_in_valid = 1'b0;
      exp2 = '0;
      for (int l = 0; l < Z2; l++) exp2[l*6 +: 6] = 6'(clamp(31 - 0, 31));
      chk("a6_vn_msg", 512'(bus2.vn_msg_out), exp2);
      chk("a6_sat_before", 512'(bus2.sat_flag), 512'(0));
      for (int l = 0; l < Z2; l++) bus2.cn_msg_in[l] = 6'd31;
      bus2.cn_msg_in_valid = 1'b1;
      #1;
      chk("a6_cn_ready", 512'(bus2.cn_msg_in_ready), 512'(1));
      @(negedge clk);
      bus2.cn_msg_in_valid = 1'b0;
      exp2 = '0;
      for (int l = 0; l < Z2; l++) exp2[l*6 +: 6] = 6'(clamp(31 + 31, 31));
      chk("a6_app_out_valid", 512'(bus2.app_out_valid), 512'(1));
      chk("a6_app_out", 512'(bus2.app_out), exp2);
      chk("a6_sat_after", 512'(bus2.sat_flag), 512'(1));
      @(negedge clk);
      chk("a6_layer_done", 512'(bus2.layer_done), 512'(1));
      $display("narrow-app layer deg=1 clipped");
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
